// File: rtl/bas_ctrl_pkg.sv
// Shared encodings for the basic-computer control unit: bus select codes,
// ALU operations, opcodes, timing states and register-reference bit positions.
package bas_ctrl_pkg;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_TR   = 3'd6;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  localparam logic [2:0] ALU_PASS_DR = 3'd0;
  localparam logic [2:0] ALU_AND     = 3'd1;
  localparam logic [2:0] ALU_ADD     = 3'd2;
  localparam logic [2:0] ALU_CMA     = 3'd3;
  localparam logic [2:0] ALU_CIR     = 3'd4;
  localparam logic [2:0] ALU_CIL     = 3'd5;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, T7} tstate_e;

  localparam int unsigned RR_CLA = 11;
  localparam int unsigned RR_CLE = 10;
  localparam int unsigned RR_CMA = 9;
  localparam int unsigned RR_CME = 8;
  localparam int unsigned RR_CIR = 7;
  localparam int unsigned RR_CIL = 6;
  localparam int unsigned RR_INC = 5;
  localparam int unsigned RR_SPA = 4;
  localparam int unsigned RR_SNA = 3;
  localparam int unsigned RR_SZA = 2;
  localparam int unsigned RR_SZE = 1;
  localparam int unsigned RR_HLT = 0;

  // All selected skip conditions collapse into one PC increment.
  function automatic logic rr_skip(input logic [11:0] rr, input logic ac_msb,
                                   input logic ac_zero, input logic e_flag);
    return (rr[RR_SPA] & ~ac_msb) | (rr[RR_SNA] & ac_msb) |
           (rr[RR_SZA] & ac_zero) | (rr[RR_SZE] & ~e_flag);
  endfunction

endpackage

// File: rtl/seq_counter.sv
// 3-bit timing sequence counter; clear has priority over increment.
module seq_counter (
  input  logic       CLK,
  input  logic       RST,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [2:0] cnt_o
);

  logic [2:0] cnt_q, cnt_d;

  // Next count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 3'd0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 3'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/basic_control_unit.sv
// Timing and control unit of the basic computer: sequences fetch, decode,
// indirect and execute phases and drives the datapath strobes combinationally.
module basic_control_unit
  import bas_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [DATA_W-1:0] ir_data,
  input  logic              ac_msb,
  input  logic              ac_zero,
  input  logic              e_flag,
  input  logic              dr_zero,
  output logic [2:0]        buscode,
  output logic              ar_ld,
  output logic              ar_inc,
  output logic              pc_ld,
  output logic              pc_inc,
  output logic              dr_ld,
  output logic              dr_inc,
  output logic              ac_ld,
  output logic              ac_inc,
  output logic              ac_clr,
  output logic              ir_ld,
  output logic              mem_wr,
  output logic [2:0]        alu_op,
  output logic              e_clr,
  output logic              e_cmp,
  output logic [2:0]        sc,
  output logic              running
);

  logic              s_q, s_d, i_q, i_d;
  logic [2:0]        d_q, d_d;
  logic              sc_clr_s, sc_inc_s;
  logic [ADDR_W-1:0] rr_s;
  tstate_e           t_s;

  assign rr_s    = ir_data[ADDR_W-1:0];
  assign t_s     = tstate_e'(sc);
  assign running = s_q;

  seq_counter u_seq_counter (
    .CLK   (CLK),
    .RST   (RST),
    .clr_i (sc_clr_s),
    .inc_i (sc_inc_s),
    .cnt_o (sc)
  );

  // Control flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s_q <= 1'b0;
      i_q <= 1'b0;
      d_q <= 3'd0;
    end else begin
      s_q <= s_d;
      i_q <= i_d;
      d_q <= d_d;
    end
  end

  // Decode of timing state and opcode into strobes and flag updates.
  always_comb begin
    buscode = BUS_NONE;
    alu_op  = ALU_PASS_DR;
    {ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc} = 6'b0;
    {ac_ld, ac_inc, ac_clr, ir_ld, mem_wr, e_clr, e_cmp} = 7'b0;
    sc_clr_s = 1'b0;
    sc_inc_s = s_q;
    s_d = s_q;
    i_d = i_q;
    d_d = d_q;
    if (!s_q) begin
      // Halted: SC stays at 0 and the next running cycle is T0.
      if (start) begin
        s_d = 1'b1;
      end else begin
        s_d = 1'b0;
      end
    end else begin
      case (t_s)
        T0: begin
          buscode = BUS_PC;
          ar_ld   = 1'b1;
        end
        T1: begin
          buscode = BUS_MEM;
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
        end
        T2: begin
          buscode = BUS_IR;
          ar_ld   = 1'b1;
          i_d     = ir_data[DATA_W-1];
          d_d     = ir_data[DATA_W-2:DATA_W-4];
        end
        T3: begin
          if (d_q == OP_REG) begin
            sc_clr_s = 1'b1;
            if (!i_q) begin
              ac_clr = rr_s[RR_CLA];
              e_clr  = rr_s[RR_CLE];
              e_cmp  = rr_s[RR_CME];
              ac_inc = rr_s[RR_INC];
              pc_inc = rr_skip(rr_s, ac_msb, ac_zero, e_flag);
              if (rr_s[RR_CMA]) begin
                alu_op = ALU_CMA;
                ac_ld  = 1'b1;
              end else if (rr_s[RR_CIR]) begin
                alu_op = ALU_CIR;
                ac_ld  = 1'b1;
              end else if (rr_s[RR_CIL]) begin
                alu_op = ALU_CIL;
                ac_ld  = 1'b1;
              end else begin
                alu_op = ALU_PASS_DR;
              end
              if (rr_s[RR_HLT]) begin
                s_d = 1'b0;
              end else begin
                s_d = s_q;
              end
            end else begin
              sc_clr_s = 1'b1;
            end
          end else if (i_q) begin
            buscode = BUS_MEM;
            ar_ld   = 1'b1;
          end else begin
            buscode = BUS_NONE;
          end
        end
        T4: begin
          case (d_q)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              buscode = BUS_MEM;
              dr_ld   = 1'b1;
            end
            OP_STA: begin
              buscode  = BUS_AC;
              mem_wr   = 1'b1;
              sc_clr_s = 1'b1;
            end
            OP_BUN: begin
              buscode  = BUS_AR;
              pc_ld    = 1'b1;
              sc_clr_s = 1'b1;
            end
            OP_BSA: begin
              buscode = BUS_PC;
              mem_wr  = 1'b1;
              ar_inc  = 1'b1;
            end
            default: sc_clr_s = 1'b1;
          endcase
        end
        T5: begin
          case (d_q)
            OP_AND: begin
              alu_op = ALU_AND; ac_ld = 1'b1; sc_clr_s = 1'b1;
            end
            OP_ADD: begin
              alu_op = ALU_ADD; ac_ld = 1'b1; sc_clr_s = 1'b1;
            end
            OP_LDA: begin
              alu_op = ALU_PASS_DR; ac_ld = 1'b1; sc_clr_s = 1'b1;
            end
            OP_BSA: begin
              buscode = BUS_AR; pc_ld = 1'b1; sc_clr_s = 1'b1;
            end
            OP_ISZ: dr_inc = 1'b1;
            default: sc_clr_s = 1'b1;
          endcase
        end
        T6: begin
          sc_clr_s = 1'b1;
          if (d_q == OP_ISZ) begin
            buscode = BUS_DR;
            mem_wr  = 1'b1;
            pc_inc  = dr_zero;
          end else begin
            buscode = BUS_NONE;
          end
        end
        default: sc_clr_s = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_basic_control_unit.sv
// Directed-vector bench for basic_control_unit: every instruction class is
// stepped cycle by cycle and all outputs are compared against hand values.
module tb_basic_control_unit;

  logic        CLK, RST, start, ac_msb, ac_zero, e_flag, dr_zero;
  logic [15:0] ir_data;
  logic [2:0]  buscode, alu_op, sc;
  logic        ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc;
  logic        ac_ld, ac_inc, ac_clr, ir_ld, mem_wr, e_clr, e_cmp, running;
  logic [18:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [12:0] AR_LD  = 13'h1000, AR_INC = 13'h0800, PC_LD  = 13'h0400;
  localparam logic [12:0] PC_INC = 13'h0200, DR_LD  = 13'h0100, DR_INC = 13'h0080;
  localparam logic [12:0] AC_LD  = 13'h0040, AC_INC = 13'h0020, AC_CLR = 13'h0010;
  localparam logic [12:0] IR_LD  = 13'h0008, MEM_WR = 13'h0004, E_CLR  = 13'h0002;
  localparam logic [12:0] E_CMP  = 13'h0001, NONE   = 13'h0000;

  basic_control_unit dut (
    .CLK(CLK), .RST(RST), .start(start), .ir_data(ir_data),
    .ac_msb(ac_msb), .ac_zero(ac_zero), .e_flag(e_flag), .dr_zero(dr_zero),
    .buscode(buscode), .ar_ld(ar_ld), .ar_inc(ar_inc), .pc_ld(pc_ld),
    .pc_inc(pc_inc), .dr_ld(dr_ld), .dr_inc(dr_inc), .ac_ld(ac_ld),
    .ac_inc(ac_inc), .ac_clr(ac_clr), .ir_ld(ir_ld), .mem_wr(mem_wr),
    .alu_op(alu_op), .e_clr(e_clr), .e_cmp(e_cmp), .sc(sc), .running(running)
  );

  assign obs = {buscode, alu_op, ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc,
                ac_ld, ac_inc, ac_clr, ir_ld, mem_wr, e_clr, e_cmp};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [18:0] ev(input logic [2:0] bus, input logic [2:0] alu,
                                     input logic [12:0] strb);
    return {bus, alu, strb};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [2:0] sc_e,
                              input logic run_e, input logic [18:0] o_e);
    check_eq({tag, "_sc"}, {29'd0, sc}, {29'd0, sc_e});
    check_eq({tag, "_run"}, {31'd0, running}, {31'd0, run_e});
    check_eq({tag, "_outs"}, {13'd0, obs}, {13'd0, o_e});
  endtask

  // Called while in T0; leaves the unit in T2.
  task automatic fetch(input string tag, input logic [15:0] ir);
    ir_data = ir;
    step(); expect_state({tag, "_T1"}, 3'd1, 1'b1, ev(3'd7, 3'd0, IR_LD | PC_INC));
    step(); expect_state({tag, "_T2"}, 3'd2, 1'b1, ev(3'd5, 3'd0, AR_LD));
  endtask

  task automatic regref(input string tag, input logic [15:0] ir, input logic [18:0] o_e);
    fetch(tag, ir);
    step(); expect_state({tag, "_T3"}, 3'd3, 1'b1, o_e);
    step(); expect_state({tag, "_T0"}, 3'd0, 1'b1, ev(3'd2, 3'd0, AR_LD));
  endtask

  task automatic isz(input string tag, input logic dz);
    fetch(tag, 16'hE010);
    step(); expect_state({tag, "_T3"}, 3'd3, 1'b1, ev(3'd7, 3'd0, AR_LD));
    step(); expect_state({tag, "_T4"}, 3'd4, 1'b1, ev(3'd7, 3'd0, DR_LD));
    step(); expect_state({tag, "_T5"}, 3'd5, 1'b1, ev(3'd0, 3'd0, DR_INC));
    dr_zero = dz;
    step(); expect_state({tag, "_T6"}, 3'd6, 1'b1, ev(3'd3, 3'd0, MEM_WR | (dz ? PC_INC : NONE)));
    dr_zero = 1'b0;
    step(); expect_state({tag, "_T0"}, 3'd0, 1'b1, ev(3'd2, 3'd0, AR_LD));
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; ir_data = 16'h0000;
    ac_msb = 1'b0; ac_zero = 1'b0; e_flag = 1'b0; dr_zero = 1'b0;
    step(); step();
    expect_state("reset", 3'd0, 1'b0, ev(3'd0, 3'd0, NONE));
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); expect_state("halted", 3'd0, 1'b0, ev(3'd0, 3'd0, NONE));
    end

    start = 1'b1;
    step(); expect_state("start_T0", 3'd0, 1'b1, ev(3'd2, 3'd0, AR_LD));
    start = 1'b0;

    // LDA direct
    fetch("lda", 16'h2005);
    step(); expect_state("lda_T3", 3'd3, 1'b1, ev(3'd0, 3'd0, NONE));
    step(); expect_state("lda_T4", 3'd4, 1'b1, ev(3'd7, 3'd0, DR_LD));
    step(); expect_state("lda_T5", 3'd5, 1'b1, ev(3'd0, 3'd0, AC_LD));
    step(); expect_state("lda_T0", 3'd0, 1'b1, ev(3'd2, 3'd0, AR_LD));

    isz("isz_z", 1'b1);
    isz("isz_nz", 1'b0);

    // BSA direct
    fetch("bsa", 16'h5020);
    step(); expect_state("bsa_T3", 3'd3, 1'b1, ev(3'd0, 3'd0, NONE));
    step(); expect_state("bsa_T4", 3'd4, 1'b1, ev(3'd2, 3'd0, MEM_WR | AR_INC));
    step(); expect_state("bsa_T5", 3'd5, 1'b1, ev(3'd1, 3'd0, PC_LD));
    step(); expect_state("bsa_T0", 3'd0, 1'b1, ev(3'd2, 3'd0, AR_LD));

    // Register-reference and I/O
    regref("spa_pos", 16'h7010, ev(3'd0, 3'd0, PC_INC));
    ac_msb = 1'b1;
    regref("spa_neg", 16'h7010, ev(3'd0, 3'd0, NONE));
    regref("sna_neg", 16'h7008, ev(3'd0, 3'd0, PC_INC));
    ac_msb = 1'b0;
    regref("cla_cma_cir", 16'h7A80, ev(3'd0, 3'd3, AC_CLR | AC_LD));
    regref("cme_cil", 16'h7140, ev(3'd0, 3'd5, AC_LD | E_CMP));
    regref("inc_cle", 16'h7420, ev(3'd0, 3'd0, AC_INC | E_CLR));
    regref("io_nop", 16'hF800, ev(3'd0, 3'd0, NONE));

    // HLT
    fetch("hlt", 16'h7001);
    step(); expect_state("hlt_T3", 3'd3, 1'b1, ev(3'd0, 3'd0, NONE));
    step(); expect_state("hlt_after", 3'd0, 1'b0, ev(3'd0, 3'd0, NONE));
    step(); expect_state("hlt_stay", 3'd0, 1'b0, ev(3'd0, 3'd0, NONE));

    // Reset in the middle of STA's write cycle
    start = 1'b1;
    step(); expect_state("restart", 3'd0, 1'b1, ev(3'd2, 3'd0, AR_LD));
    start = 1'b0;
    fetch("sta", 16'h3004);
    step(); expect_state("sta_T3", 3'd3, 1'b1, ev(3'd0, 3'd0, NONE));
    step(); expect_state("sta_T4", 3'd4, 1'b1, ev(3'd4, 3'd0, MEM_WR));
    RST = 1'b1;
    #1;
    expect_state("rst_abort", 3'd0, 1'b0, ev(3'd0, 3'd0, NONE));
    step();
    RST = 1'b0;
    step(); expect_state("rst_after", 3'd0, 1'b0, ev(3'd0, 3'd0, NONE));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/basic_control_unit.md
Name: basic_control_unit

Overview:
- Timing and control unit for the basic-computer datapath.
- Holds the sequence counter (SC), the indirect flag I, the decoded opcode D and the run flag S.
- Each cycle it drives the 3-bit bus select code into buschooser, plus register load/inc/clr strobes, the memory write strobe and the ALU op.
- Sequences fetch, decode, indirect and execute for memory-reference and register-reference instructions; I/O instructions are treated as NOP.

Parameters:
DATA_W, 16, datapath/IR width (fixed encoding assumes 16)
ADDR_W, 12, address width (AR/PC)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, asynchronous, active-high
start  in  1  level; sets S when halted
ir_data  in  DATA_W  IR register contents
ac_msb  in  1  AC[15]
ac_zero  in  1  AC==0
e_flag  in  1  E flip-flop value
dr_zero  in  1  DR==0 (combinational from DR)
buscode  out  3  bus select: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM
ar_ld/ar_inc  out  1 each  AR strobes
pc_ld/pc_inc  out  1 each  PC strobes
dr_ld/dr_inc  out  1 each  DR strobes
ac_ld/ac_inc/ac_clr  out  1 each  AC strobes
ir_ld  out  1  IR load
mem_wr  out  1  memory write M[AR]<-bus
alu_op  out  3  0 PASS_DR, 1 AND, 2 ADD, 3 CMA, 4 CIR, 5 CIL
e_clr/e_cmp  out  1 each  E control
sc  out  3  current timing state T0..T6
running  out  1  S flag

Behaviour:
- State: SC (3b), I (1b), D (3b), S (1b).
- RST: asynchronous clear of SC=0, I=0, D=0, S=0.
- All outputs are combinational from state and inputs. With S=0, every strobe, buscode and alu_op is 0.
- Reset asserted mid-instruction aborts immediately; no partial write completes after the RST edge.
- S=0 and start=1: S<=1 at the next edge. The next cycle is T0; SC holds 0 while halted.
- SC increments every cycle while S=1 unless "SC clr" is stated; SC clr returns to T0 at the next edge.
- T0: buscode=2, ar_ld.
- T1: buscode=7, ir_ld, pc_inc.
- T2: buscode=5, ar_ld (AR gets ir_data[11:0]); latch I<=ir_data[15], D<=ir_data[14:12].
- T3 with D=7:
  - I=0: register-reference; assert all strobes for set bits, then SC clr.
    - B11 ac_clr; B10 e_clr; B9 alu_op=CMA+ac_ld; B8 e_cmp; B7 CIR+ac_ld; B6 CIL+ac_ld; B5 ac_inc.
    - Skips: B4 SPA (pc_inc if !ac_msb), B3 SNA (if ac_msb), B2 SZA (if ac_zero), B1 SZE (if !e_flag).
    - B0 HLT: S<=0.
    - Multiple ALU bits set: priority CMA>CIR>CIL. Skip conditions are OR'd into a single pc_inc.
  - I=1: I/O, NOP, SC clr.
- T3 with D≠7: if I=1, buscode=7 and ar_ld (indirect); if I=0, idle.
- Execute, by D:
  - AND / ADD / LDA (D=0/1/2): T4 buscode=7, dr_ld. T5 alu_op=AND/ADD/PASS_DR, ac_ld, SC clr. ADD carry updates E inside the ALU.
  - STA (D=3): T4 buscode=4, mem_wr, SC clr.
  - BUN (D=4): T4 buscode=1, pc_ld, SC clr.
  - BSA (D=5): T4 buscode=2, mem_wr, ar_inc. T5 buscode=1, pc_ld, SC clr.
  - ISZ (D=6): T4 buscode=7, dr_ld. T5 dr_inc. T6 buscode=3, mem_wr, pc_inc if dr_zero, SC clr.
- SC never exceeds 6. An unreachable SC=7 forces SC clr with no strobes.
- start while S=1 is ignored. HLT takes effect at the end of T3; the following cycle all outputs are 0.

Decomposition:
- Package bas_ctrl_pkg:
  - BUS_* codes 0..7 (shared with buschooser)
  - ALU_* codes
  - opcode constants OP_AND..OP_REG
  - register-ref bit indices
- Sub-module seq_counter: 3-bit counter with clr and inc, async active-high RST.

Test Plan:
- RST=1 then release, start=0 for 5 cycles -> buscode=0, all strobes 0, sc=0, running=0. Then start=1 -> running=1 next cycle; T0 buscode=2 with ar_ld.
- LDA direct: ir_data=16'h2005 -> T1 buscode=7+ir_ld+pc_inc; T2 buscode=5+ar_ld; T4 buscode=7+dr_ld; T5 alu_op=0+ac_ld; sc=0 next.
- ISZ indirect: ir_data=16'hE010, dr_zero=1 at T6 -> T3 buscode=7+ar_ld; T6 buscode=3+mem_wr+pc_inc. Repeat with dr_zero=0 -> pc_inc=0.
- BSA: ir_data=16'h5020 -> T4 buscode=2+mem_wr+ar_inc; T5 buscode=1+pc_ld.
- Register-ref: ir_data=16'h7010 (SPA) with ac_msb=0 -> T3 pc_inc=1. Then 16'h7001 (HLT) -> running=0 and all outputs 0 from the next cycle.
- RST pulse at T4 of STA (ir_data=16'h3004) -> mem_wr deasserts immediately, sc=0, running=0.
